// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction-fetch controller.
package fetch_pkg;
  typedef enum logic [1:0] {REQ, WAIT, DROP, HOLD} state_t;
  localparam int PC_STEP = 4;
  localparam logic [31:0] RESET_PC = 32'hbfc00000;
endpackage

// File: rtl/fetch_redirect_buf.sv
// fetch_redirect_buf: holds the most recent redirect target until the fetch
// controller locks it as a fetch address.
module fetch_redirect_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_set,
  input  logic [WIDTH-1:0] i_pc,
  input  logic             i_consume,
  output logic [WIDTH-1:0] o_pend_pc,
  output logic             o_pend_valid
);
  logic [WIDTH-1:0] r_pend_pc;
  logic             r_pend_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_pc    <= '0;
      r_pend_valid <= 1'b0;
    end else if (i_set) begin
      r_pend_pc    <= i_pc;
      r_pend_valid <= 1'b1;
    end else if (i_consume) begin
      r_pend_valid <= 1'b0;
    end
  end
  assign o_pend_pc    = r_pend_pc;
  assign o_pend_valid = r_pend_valid;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch between PC selector and decode.
// Define FETCH_PERF_CNT_EN to add saturating fetch/drop performance counters.
module fetch_ctrl #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pc_des,
  input  logic             redirect,
  output logic [WIDTH-1:0] pc_seq,
  output logic             pc_en,
  output logic             inst_req,
  output logic [WIDTH-1:0] inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [WIDTH-1:0] inst_rdata,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_inst,
  output logic             if_adel,
  input  logic             id_allowin
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      perf_fetch_cnt,
  output logic [31:0]      perf_drop_cnt
`endif
);
  import fetch_pkg::*;
  state_t           r_state;
  logic             r_lock;
  logic             r_cancel;
  logic [WIDTH-1:0] r_addr_q;
  logic [WIDTH-1:0] r_if_pc;
  logic [WIDTH-1:0] r_if_inst;
  logic             r_if_adel;
  logic [WIDTH-1:0] w_pend_pc;
  logic             w_pend_valid;
  logic [WIDTH-1:0] w_fa;
  logic             w_cancel;
  logic             w_consume;
  // A redirect in the same cycle as an unlocked REQ defers locking by one
  // cycle so the new target is taken from the buffer, never a stale one.
  assign w_consume = (r_state == REQ) && !r_lock && !redirect;
  assign w_fa      = w_pend_valid ? w_pend_pc : pc_des;
  assign w_cancel  = r_cancel || redirect;
  fetch_redirect_buf #(.WIDTH(WIDTH)) u_redirect_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_set        (redirect),
    .i_pc         (pc_des),
    .i_consume    (w_consume),
    .o_pend_pc    (w_pend_pc),
    .o_pend_valid (w_pend_valid)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= REQ;
      r_lock    <= 1'b0;
      r_cancel  <= 1'b0;
      r_addr_q  <= RESET_PC;
      r_if_pc   <= '0;
      r_if_inst <= '0;
      r_if_adel <= 1'b0;
    end else begin
      case (r_state)
        REQ:
          if (!r_lock) begin
            if (w_consume && w_fa[1:0] != 2'b00) begin
              r_if_pc   <= w_fa;
              r_if_inst <= '0;
              r_if_adel <= 1'b1;
              r_state   <= HOLD;
            end else if (w_consume) begin
              r_addr_q <= w_fa;
              r_lock   <= 1'b1;
            end
          end else if (inst_addr_ok) begin
            r_lock   <= 1'b0;
            r_cancel <= 1'b0;
            if (w_cancel) r_state <= DROP;
            else begin
              r_if_pc <= r_addr_q;
              r_state <= WAIT;
            end
          end else if (redirect) r_cancel <= 1'b1;
        WAIT:
          if (redirect) r_state <= inst_data_ok ? REQ : DROP;
          else if (inst_data_ok) begin
            r_if_inst <= inst_rdata;
            r_if_adel <= 1'b0;
            r_state   <= HOLD;
          end
        DROP:
          if (inst_data_ok) r_state <= REQ;
        HOLD:
          if (redirect || id_allowin) r_state <= REQ;
        default: r_state <= REQ;
      endcase
    end
  end
  assign inst_req  = (r_state == REQ) && r_lock;
  assign inst_addr = r_addr_q;
  assign pc_en     = inst_req && inst_addr_ok && !w_cancel;
  assign pc_seq    = r_addr_q + WIDTH'(PC_STEP);
  assign if_valid  = (r_state == HOLD) && !redirect;
  assign if_pc     = r_if_pc;
  assign if_inst   = r_if_inst;
  assign if_adel   = r_if_adel;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_drop_cnt;
  logic        w_drop;
  assign w_drop = inst_data_ok && ((r_state == DROP) || (r_state == WAIT && redirect));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (pc_en && r_fetch_cnt != '1) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 32'd1;
    end
  end
  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_drop_cnt  = r_drop_cnt;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: table-driven per-cycle vectors plus hand sequences for
// reset-mid-transaction and pc_seq wrap-around.
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_des = '0;
  logic        redirect = 1'b0;
  logic [31:0] pc_seq;
  logic        pc_en;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;
  logic        id_allowin = 1'b0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_drop_cnt;
`endif
  int n_tests = 0;
  int n_fail = 0;

  fetch_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_des       (pc_des),
    .redirect     (redirect),
    .pc_seq       (pc_seq),
    .pc_en        (pc_en),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_adel      (if_adel),
    .id_allowin   (id_allowin)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]  pc;
    logic         rd;
    logic         aok;
    logic         dok;
    logic [31:0]  rdat;
    logic         alw;
    logic [131:0] exp;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic [31:0] pc, input logic rd, aok, dok, input logic [31:0] rdat,
                     input logic alw, input logic req, input logic [31:0] addr, input logic pcen,
                     input logic [31:0] seq, input logic val, input logic [31:0] ifpc,
                     input logic [31:0] inst, input logic adel);
    vec_t v;
    v.pc = pc; v.rd = rd; v.aok = aok; v.dok = dok; v.rdat = rdat; v.alw = alw;
    v.exp = {req, addr, pcen, seq, val, ifpc, inst, adel};
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [131:0] outs();
    return {inst_req, inst_addr, pc_en, pc_seq, if_valid, if_pc, if_inst, if_adel};
  endfunction

  initial begin
    // reset-release fetch, addr_ok 1 cycle after lock, data 2 cycles after accept
    add(32'hbfc00000,0,0,0,0,0, 0,32'hbfc00000,0,32'hbfc00004,0,0,0,0);
    add(32'hbfc00000,0,1,0,0,0, 1,32'hbfc00000,1,32'hbfc00004,0,0,0,0);
    add(32'hbfc00004,0,0,0,0,0, 0,32'hbfc00000,0,32'hbfc00004,0,32'hbfc00000,0,0);
    add(32'hbfc00004,0,0,1,32'h24080001,0, 0,32'hbfc00000,0,32'hbfc00004,0,32'hbfc00000,0,0);
    add(32'hbfc00004,0,0,0,0,1, 0,32'hbfc00000,0,32'hbfc00004,1,32'hbfc00000,32'h24080001,0);
    // addr_ok withheld 3 cycles while pc_des moves
    add(32'hbfc00004,0,0,0,0,0, 0,32'hbfc00000,0,32'hbfc00004,0,32'hbfc00000,32'h24080001,0);
    add(32'hbfc00008,0,0,0,0,0, 1,32'hbfc00004,0,32'hbfc00008,0,32'hbfc00000,32'h24080001,0);
    add(32'hbfc0000c,0,0,0,0,0, 1,32'hbfc00004,0,32'hbfc00008,0,32'hbfc00000,32'h24080001,0);
    add(32'hbfc00010,0,0,0,0,0, 1,32'hbfc00004,0,32'hbfc00008,0,32'hbfc00000,32'h24080001,0);
    add(32'hbfc00010,0,1,0,0,0, 1,32'hbfc00004,1,32'hbfc00008,0,32'hbfc00000,32'h24080001,0);
    // redirect during WAIT -> DROP, refetch from pend
    add(32'hbfc00100,1,0,0,0,0, 0,32'hbfc00004,0,32'hbfc00008,0,32'hbfc00004,32'h24080001,0);
    add(32'hbfc00200,0,0,1,32'hdeadbeef,0, 0,32'hbfc00004,0,32'hbfc00008,0,32'hbfc00004,32'h24080001,0);
    add(32'hbfc00200,0,0,0,0,0, 0,32'hbfc00004,0,32'hbfc00008,0,32'hbfc00004,32'h24080001,0);
    add(32'hbfc00200,0,1,0,0,0, 1,32'hbfc00100,1,32'hbfc00104,0,32'hbfc00004,32'h24080001,0);
    add(32'hbfc00104,0,0,1,32'h11112222,0, 0,32'hbfc00100,0,32'hbfc00104,0,32'hbfc00100,32'h24080001,0);
    add(32'hbfc00104,0,0,0,0,1, 0,32'hbfc00100,0,32'hbfc00104,1,32'hbfc00100,32'h11112222,0);
    // redirect while locked -> cancelled accept, DROP, refetch from pend
    add(32'hbfc00104,0,0,0,0,0, 0,32'hbfc00100,0,32'hbfc00104,0,32'hbfc00100,32'h11112222,0);
    add(32'hbfc00100,1,0,0,0,0, 1,32'hbfc00104,0,32'hbfc00108,0,32'hbfc00100,32'h11112222,0);
    add(32'hbfc00300,0,0,0,0,0, 1,32'hbfc00104,0,32'hbfc00108,0,32'hbfc00100,32'h11112222,0);
    add(32'hbfc00300,0,1,0,0,0, 1,32'hbfc00104,0,32'hbfc00108,0,32'hbfc00100,32'h11112222,0);
    add(32'hbfc00300,0,0,0,0,0, 0,32'hbfc00104,0,32'hbfc00108,0,32'hbfc00100,32'h11112222,0);
    add(32'hbfc00300,0,0,1,32'hdeadbeef,0, 0,32'hbfc00104,0,32'hbfc00108,0,32'hbfc00100,32'h11112222,0);
    add(32'hbfc00300,0,0,0,0,0, 0,32'hbfc00104,0,32'hbfc00108,0,32'hbfc00100,32'h11112222,0);
    add(32'hbfc00300,0,1,0,0,0, 1,32'hbfc00100,1,32'hbfc00104,0,32'hbfc00100,32'h11112222,0);
    add(32'hbfc00104,0,0,1,32'h33334444,0, 0,32'hbfc00100,0,32'hbfc00104,0,32'hbfc00100,32'h11112222,0);
    add(32'hbfc00104,0,0,0,0,1, 0,32'hbfc00100,0,32'hbfc00104,1,32'hbfc00100,32'h33334444,0);
    // misaligned fetch address: no request, held adel until allowin
    add(32'hbfc00102,0,0,0,0,0, 0,32'hbfc00100,0,32'hbfc00104,0,32'hbfc00100,32'h33334444,0);
    add(32'hbfc00102,0,0,0,0,0, 0,32'hbfc00100,0,32'hbfc00104,1,32'hbfc00102,0,1);
    add(32'hbfc00102,0,0,0,0,0, 0,32'hbfc00100,0,32'hbfc00104,1,32'hbfc00102,0,1);
    add(32'hbfc00102,0,0,0,0,1, 0,32'hbfc00100,0,32'hbfc00104,1,32'hbfc00102,0,1);
    // HOLD stalled 5 cycles, then redirect wins over allowin
    add(32'hbfc00400,0,0,0,0,0, 0,32'hbfc00100,0,32'hbfc00104,0,32'hbfc00102,0,1);
    add(32'hbfc00400,0,1,0,0,0, 1,32'hbfc00400,1,32'hbfc00404,0,32'hbfc00102,0,1);
    add(32'hbfc00404,0,0,1,32'h55556666,0, 0,32'hbfc00400,0,32'hbfc00404,0,32'hbfc00400,0,1);
    for (int i = 0; i < 5; i++)
      add(32'hbfc00404,0,0,0,0,0, 0,32'hbfc00400,0,32'hbfc00404,1,32'hbfc00400,32'h55556666,0);
    add(32'hbfc00500,1,0,0,0,1, 0,32'hbfc00400,0,32'hbfc00404,0,32'hbfc00400,32'h55556666,0);
    add(32'hbfc00600,0,0,0,0,0, 0,32'hbfc00400,0,32'hbfc00404,0,32'hbfc00400,32'h55556666,0);
    add(32'hbfc00600,0,1,0,0,0, 1,32'hbfc00500,1,32'hbfc00504,0,32'hbfc00400,32'h55556666,0);
    add(32'hbfc00504,0,0,1,32'h77778888,0, 0,32'hbfc00500,0,32'hbfc00504,0,32'hbfc00500,32'h55556666,0);
    add(32'hbfc00504,0,0,0,0,1, 0,32'hbfc00500,0,32'hbfc00504,1,32'hbfc00500,32'h77778888,0);
    // redirect together with data_ok in WAIT -> straight back to REQ
    add(32'hbfc00700,0,0,0,0,0, 0,32'hbfc00500,0,32'hbfc00504,0,32'hbfc00500,32'h77778888,0);
    add(32'hbfc00700,0,1,0,0,0, 1,32'hbfc00700,1,32'hbfc00704,0,32'hbfc00500,32'h77778888,0);
    add(32'hbfc00800,1,0,1,32'h99990000,0, 0,32'hbfc00700,0,32'hbfc00704,0,32'hbfc00700,32'h77778888,0);
    add(32'hbfc00900,0,0,0,0,0, 0,32'hbfc00700,0,32'hbfc00704,0,32'hbfc00700,32'h77778888,0);
    add(32'hbfc00900,0,0,0,0,0, 1,32'hbfc00800,0,32'hbfc00804,0,32'hbfc00700,32'h77778888,0);

    repeat (2) @(negedge clk);
    chk("reset inst_req", 132'(inst_req), 132'(0));
    chk("reset pc_en", 132'(pc_en), 132'(0));
    chk("reset if_valid", 132'(if_valid), 132'(0));
    chk("reset if_pc/inst/adel", {if_pc, if_inst, if_adel}, 132'(0));
    rst_n = 1'b1;
    foreach (vq[i]) begin
      pc_des = vq[i].pc; redirect = vq[i].rd; inst_addr_ok = vq[i].aok;
      inst_data_ok = vq[i].dok; inst_rdata = vq[i].rdat; id_allowin = vq[i].alw;
      #2;
      chk($sformatf("vec%0d", i), outs(), vq[i].exp);
      @(negedge clk);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch_cnt", 132'(perf_fetch_cnt), 132'(7));
    chk("perf_drop_cnt", 132'(perf_drop_cnt), 132'(3));
`endif
    // asynchronous reset while a request is outstanding
    pc_des = '0; redirect = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
    inst_rdata = '0; id_allowin = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset inst_req", 132'(inst_req), 132'(0));
    chk("midreset if_pc/inst/adel", {if_pc, if_inst, if_adel}, 132'(0));
    // pc_seq wrap at the top of the address space
    @(negedge clk);
    rst_n = 1'b1;
    pc_des = 32'hfffffffc;
    #2;
    chk("wrap pre-lock inst_req", 132'(inst_req), 132'(0));
    @(negedge clk);
    inst_addr_ok = 1'b1;
    #2;
    chk("wrap accept", {inst_req, inst_addr, pc_en, pc_seq}, {1'b1, 32'hfffffffc, 1'b1, 32'h0});
    @(negedge clk);
    inst_addr_ok = 1'b0;
    repeat (2) @(negedge clk);
    inst_data_ok = 1'b1; inst_rdata = 32'habcd0123;
    @(negedge clk);
    inst_data_ok = 1'b0; inst_rdata = '0;
    for (int k = 0; k < 8; k++) begin
      #2;
      if (if_valid) break;
      @(negedge clk);
    end
    chk("wrap if_valid", 132'(if_valid), 132'(1));
    chk("wrap if_pc/inst/adel", {if_pc, if_inst, if_adel}, {32'hfffffffc, 32'habcd0123, 1'b0});
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
